cc_branch_unit: RTL and testbench

Parametrised condition-code and branch-enable unit for the SLC-3 datapath, a generalisation of the fixed 16-bit NZP/BEN logic. It derives N/Z/P from a DATA_W-wide bus and holds them in a condition-code register. It evaluates BEN against IR[11:9] and keeps a CC save/restore stack of depth STACK_DEPTH for interrupt entry and return. It sits beside the register file and is driven by the control FSM through LD_CC, LD_BEN, LD_PSR_CC, CC_PUSH and CC_POP.

---
 rtl/cc_branch_unit.sv | 131 +++++++++++++
 tb/tb_cc_branch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_unit.sv
// Condition-code register, branch-enable evaluation and CC save/restore stack.
// Optional macro CC_BYPASS_EN: BEN evaluates against the CC value being loaded in the same cycle.
module cc_branch_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataBus,
    input  logic [2:0]        IR_11_9,
    input  logic              LD_CC,
    input  logic              LD_PSR_CC,
    input  logic              LD_BEN,
    input  logic              CC_PUSH,
    input  logic              CC_POP,
    output logic [2:0]        CC,
    output logic              BEN,
    output logic [CNT_W-1:0]  STACK_COUNT,
    output logic              STACK_FULL,
    output logic              STACK_EMPTY,
    output logic              STACK_ERR
);

    logic [2:0]       cc_q, cc_d;
    logic             ben_q, ben_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [2:0]       stack_q [STACK_DEPTH];
    logic [2:0]       stack_d [STACK_DEPTH];

    logic [2:0] flags;
    logic [2:0] stack_top;
    logic [2:0] cc_src;
    logic       stack_full, stack_empty;
    logic       push_ok, pop_ok, err_set;

    assign stack_full  = (count_q == CNT_W'(STACK_DEPTH));
    assign stack_empty = (count_q == '0);

    // One-hot N/Z/P derived from the bus; zero test takes precedence over sign.
    always_comb begin
        flags = 3'b001;
        if (DataBus == '0)
            flags = 3'b010;
        else if (DataBus[DATA_W-1])
            flags = 3'b100;
    end

    always_comb begin
        stack_top = 3'b010;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1))
                stack_top = stack_q[i];
        end
    end

    // Simultaneous push and pop is treated as a protocol error and neither happens.
    assign push_ok = CC_PUSH & ~CC_POP & ~stack_full;
    assign pop_ok  = CC_POP & ~CC_PUSH & ~stack_empty;
    assign err_set = (CC_PUSH & CC_POP) | (CC_PUSH & stack_full) | (CC_POP & stack_empty);

    always_comb begin
        cc_d = cc_q;
        if (pop_ok)
            cc_d = stack_top;
        else if (LD_PSR_CC)
            cc_d = DataBus[2:0];
        else if (LD_CC)
            cc_d = flags;
    end

`ifdef CC_BYPASS_EN
    assign cc_src = cc_d;
`else
    assign cc_src = cc_q;
`endif

    always_comb begin
        ben_d = ben_q;
        if (LD_BEN)
            ben_d = |(IR_11_9 & cc_src);
    end

    always_comb begin
        count_d = count_q;
        if (push_ok)
            count_d = count_q + CNT_W'(1);
        else if (pop_ok)
            count_d = count_q - CNT_W'(1);
    end

    assign err_d = err_q | err_set;

    // Push stores the pre-edge CC into the slot just above the current top.
    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (push_ok && (count_q == CNT_W'(i)))
                stack_d[i] = cc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cc_q    <= 3'b010;
            ben_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            ben_q   <= ben_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset; the count alone defines validity.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STACK_DEPTH; i++)
            stack_q[i] <= stack_d[i];
    end

    assign CC          = cc_q;
    assign BEN         = ben_q;
    assign STACK_COUNT = count_q;
    assign STACK_FULL  = stack_full;
    assign STACK_EMPTY = stack_empty;
    assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: CC derivation, BEN, stack LIFO and error behaviour.
module tb_cc_branch_unit;

    localparam int DATA_W      = 16;
    localparam int STACK_DEPTH = 4;
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1);

    logic              CLK;
    logic              Reset;
    logic [DATA_W-1:0] DataBus;
    logic [2:0]        IR_11_9;
    logic              LD_CC, LD_PSR_CC, LD_BEN, CC_PUSH, CC_POP;
    logic [2:0]        CC;
    logic              BEN;
    logic [CNT_W-1:0]  STACK_COUNT;
    logic              STACK_FULL, STACK_EMPTY, STACK_ERR;

    int tests_run;
    int tests_failed;

    cc_branch_unit #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .DataBus(DataBus), .IR_11_9(IR_11_9),
        .LD_CC(LD_CC), .LD_PSR_CC(LD_PSR_CC), .LD_BEN(LD_BEN),
        .CC_PUSH(CC_PUSH), .CC_POP(CC_POP),
        .CC(CC), .BEN(BEN), .STACK_COUNT(STACK_COUNT),
        .STACK_FULL(STACK_FULL), .STACK_EMPTY(STACK_EMPTY), .STACK_ERR(STACK_ERR)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too.
    task automatic idle_inputs;
        Reset = 1'b0; DataBus = '0; IR_11_9 = 3'b000;
        LD_CC = 1'b0; LD_PSR_CC = 1'b0; LD_BEN = 1'b0; CC_PUSH = 1'b0; CC_POP = 1'b0;
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset;
        Reset = 1'b1; step();
        step();
        tests_run++; if (CC !== 3'b010) begin tests_failed++; $display("FAIL reset_cc got=%b exp=010", CC); end
        tests_run++; if (BEN !== 1'b0) begin tests_failed++; $display("FAIL reset_ben got=%b exp=0", BEN); end
        tests_run++; if (STACK_COUNT !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", STACK_COUNT); end
        tests_run++; if (STACK_EMPTY !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got=%b exp=1", STACK_EMPTY); end
        tests_run++; if (STACK_FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b exp=0", STACK_FULL); end
        tests_run++; if (STACK_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", STACK_ERR); end
    endtask

    task automatic test_ld_cc;
        logic [DATA_W-1:0] bus_v [3] = '{16'h8001, 16'h0000, 16'h7FFF};
        logic [2:0]        exp_v [3] = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            LD_CC = 1'b1; DataBus = bus_v[i]; step();
            tests_run++;
            if (CC !== exp_v[i]) begin tests_failed++; $display("FAIL ld_cc_%0d got=%b exp=%b", i, CC, exp_v[i]); end
        end
        // Hold: no load leaves CC unchanged even with a different bus value.
        DataBus = 16'h8000; step();
        tests_run++; if (CC !== 3'b001) begin tests_failed++; $display("FAIL cc_hold got=%b exp=001", CC); end
    endtask

    task automatic test_ben;
        LD_BEN = 1'b1; IR_11_9 = 3'b001; step();
        tests_run++; if (BEN !== 1'b1) begin tests_failed++; $display("FAIL ben_p got=%b exp=1", BEN); end
        step();
        tests_run++; if (BEN !== 1'b1) begin tests_failed++; $display("FAIL ben_hold got=%b exp=1", BEN); end
        LD_BEN = 1'b1; IR_11_9 = 3'b110; step();
        tests_run++; if (BEN !== 1'b0) begin tests_failed++; $display("FAIL ben_nz got=%b exp=0", BEN); end
    endtask

    task automatic test_same_cycle_ben;
        logic exp_ben;
`ifdef CC_BYPASS_EN
        exp_ben = 1'b1;
`else
        exp_ben = 1'b0;
`endif
        LD_CC = 1'b1; DataBus = 16'hFFFF; LD_BEN = 1'b1; IR_11_9 = 3'b100; step();
        tests_run++; if (CC !== 3'b100) begin tests_failed++; $display("FAIL same_cycle_cc got=%b exp=100", CC); end
        tests_run++; if (BEN !== exp_ben) begin tests_failed++; $display("FAIL same_cycle_ben got=%b exp=%b", BEN, exp_ben); end
    endtask

    task automatic test_stack_fill_drain;
        logic [DATA_W-1:0] bus_v [3] = '{16'h0000, 16'h7FFF, 16'h8000};
        logic [2:0]        pop_v [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
        // CC is 100 here; push it, then load and push 010, 001, 100.
        CC_PUSH = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            LD_CC = 1'b1; DataBus = bus_v[i]; step();
            CC_PUSH = 1'b1; step();
        end
        tests_run++; if (STACK_FULL !== 1'b1) begin tests_failed++; $display("FAIL fill_full got=%b exp=1", STACK_FULL); end
        tests_run++; if (STACK_COUNT !== 3'd4) begin tests_failed++; $display("FAIL fill_count got=%0d exp=4", STACK_COUNT); end
        tests_run++; if (STACK_ERR !== 1'b0) begin tests_failed++; $display("FAIL fill_err got=%b exp=0", STACK_ERR); end
        CC_PUSH = 1'b1; step();
        tests_run++; if (STACK_ERR !== 1'b1) begin tests_failed++; $display("FAIL overflow_err got=%b exp=1", STACK_ERR); end
        tests_run++; if (STACK_COUNT !== 3'd4) begin tests_failed++; $display("FAIL overflow_count got=%0d exp=4", STACK_COUNT); end
        for (int i = 0; i < 4; i++) begin
            CC_POP = 1'b1; step();
            tests_run++;
            if (CC !== pop_v[i]) begin tests_failed++; $display("FAIL pop_%0d got=%b exp=%b", i, CC, pop_v[i]); end
            tests_run++;
            if (STACK_COUNT !== CNT_W'(3 - i)) begin tests_failed++; $display("FAIL pop_count_%0d got=%0d exp=%0d", i, STACK_COUNT, 3 - i); end
        end
        tests_run++; if (STACK_EMPTY !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got=%b exp=1", STACK_EMPTY); end
        CC_POP = 1'b1; step();
        tests_run++; if (CC !== 3'b100) begin tests_failed++; $display("FAIL underflow_cc got=%b exp=100", CC); end
        tests_run++; if (STACK_COUNT !== 3'd0) begin tests_failed++; $display("FAIL underflow_count got=%0d exp=0", STACK_COUNT); end
        tests_run++; if (STACK_ERR !== 1'b1) begin tests_failed++; $display("FAIL underflow_err got=%b exp=1", STACK_ERR); end
        // Empty pop falls through to LD_CC.
        CC_POP = 1'b1; LD_CC = 1'b1; DataBus = 16'h0000; step();
        tests_run++; if (CC !== 3'b010) begin tests_failed++; $display("FAIL underflow_fallthrough got=%b exp=010", CC); end
        tests_run++; if (STACK_COUNT !== 3'd0) begin tests_failed++; $display("FAIL underflow_count2 got=%0d exp=0", STACK_COUNT); end
    endtask

    task automatic test_push_with_load;
        LD_CC = 1'b1; DataBus = 16'h0001; step();
        CC_PUSH = 1'b1; LD_CC = 1'b1; DataBus = 16'h0000; step();
        tests_run++; if (CC !== 3'b010) begin tests_failed++; $display("FAIL push_ld_cc got=%b exp=010", CC); end
        tests_run++; if (STACK_COUNT !== 3'd1) begin tests_failed++; $display("FAIL push_ld_count got=%0d exp=1", STACK_COUNT); end
        CC_POP = 1'b1; step();
        tests_run++; if (CC !== 3'b001) begin tests_failed++; $display("FAIL push_ld_restore got=%b exp=001", CC); end
        tests_run++; if (STACK_ERR !== 1'b0) begin tests_failed++; $display("FAIL push_ld_err got=%b exp=0", STACK_ERR); end
    endtask

    task automatic test_push_pop_together;
        CC_PUSH = 1'b1; step();
        CC_PUSH = 1'b1; CC_POP = 1'b1; step();
        tests_run++; if (STACK_COUNT !== 3'd1) begin tests_failed++; $display("FAIL pushpop_count got=%0d exp=1", STACK_COUNT); end
        tests_run++; if (STACK_ERR !== 1'b1) begin tests_failed++; $display("FAIL pushpop_err got=%b exp=1", STACK_ERR); end
        tests_run++; if (CC !== 3'b001) begin tests_failed++; $display("FAIL pushpop_cc got=%b exp=001", CC); end
        CC_PUSH = 1'b1; CC_POP = 1'b1; LD_CC = 1'b1; DataBus = 16'h8000; step();
        tests_run++; if (CC !== 3'b100) begin tests_failed++; $display("FAIL pushpop_ld_cc got=%b exp=100", CC); end
        tests_run++; if (STACK_COUNT !== 3'd1) begin tests_failed++; $display("FAIL pushpop_ld_count got=%0d exp=1", STACK_COUNT); end
    endtask

    task automatic test_psr;
        LD_PSR_CC = 1'b1; DataBus = 16'h0006; step();
        tests_run++; if (CC !== 3'b110) begin tests_failed++; $display("FAIL psr_cc got=%b exp=110", CC); end
        LD_BEN = 1'b1; IR_11_9 = 3'b010; step();
        tests_run++; if (BEN !== 1'b1) begin tests_failed++; $display("FAIL psr_ben got=%b exp=1", BEN); end
        // PSR load outranks LD_CC (flags of 0x0005 would be 001).
        LD_PSR_CC = 1'b1; LD_CC = 1'b1; DataBus = 16'h0005; step();
        tests_run++; if (CC !== 3'b101) begin tests_failed++; $display("FAIL psr_prio got=%b exp=101", CC); end
        // A valid pop outranks PSR load; the top entry holds 001.
        CC_POP = 1'b1; LD_PSR_CC = 1'b1; DataBus = 16'h0006; step();
        tests_run++; if (CC !== 3'b001) begin tests_failed++; $display("FAIL pop_prio got=%b exp=001", CC); end
        tests_run++; if (STACK_COUNT !== 3'd0) begin tests_failed++; $display("FAIL pop_prio_count got=%0d exp=0", STACK_COUNT); end
    endtask

    task automatic test_reset_mid;
        LD_BEN = 1'b1; IR_11_9 = 3'b001; step();
        for (int i = 0; i < 3; i++) begin
            CC_PUSH = 1'b1; step();
        end
        tests_run++; if (STACK_COUNT !== 3'd3) begin tests_failed++; $display("FAIL mid_count_pre got=%0d exp=3", STACK_COUNT); end
        tests_run++; if (BEN !== 1'b1) begin tests_failed++; $display("FAIL mid_ben_pre got=%b exp=1", BEN); end
        Reset = 1'b1; CC_PUSH = 1'b1; LD_CC = 1'b1; DataBus = 16'h8000; step();
        tests_run++; if (STACK_COUNT !== 3'd0) begin tests_failed++; $display("FAIL mid_count got=%0d exp=0", STACK_COUNT); end
        tests_run++; if (STACK_ERR !== 1'b0) begin tests_failed++; $display("FAIL mid_err got=%b exp=0", STACK_ERR); end
        tests_run++; if (CC !== 3'b010) begin tests_failed++; $display("FAIL mid_cc got=%b exp=010", CC); end
        tests_run++; if (BEN !== 1'b0) begin tests_failed++; $display("FAIL mid_ben got=%b exp=0", BEN); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        test_reset();
        test_ld_cc();
        test_ben();
        test_same_cycle_ben();
        test_stack_fill_drain();
        Reset = 1'b1; step();
        test_push_with_load();
        test_push_pop_together();
        test_psr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
